// File: rtl/pe_tile_array.sv
// ROWS x COLS signed multiply-accumulate tile. Operand beats are streamed in,
// then the accumulators are drained one shifted/saturated row per handshake.
module pe_tile_array #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int K_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [K_W-1:0]           cfg_k,
    input  logic [5:0]               cfg_shift,
    input  logic                     cfg_relu,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ROWS*DATA_W-1:0]   a_data,
    input  logic [COLS*DATA_W-1:0]   b_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COLS*DATA_W-1:0]   out_data,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [K_W-1:0]            beat_cnt_q, beat_cnt_d;
    logic [K_W-1:0]            k_q, k_d;
    logic [5:0]                shift_q, shift_d;
    logic                      relu_q, relu_d;
    logic signed [ACC_W-1:0]   acc_q [ROWS][COLS];
    logic signed [ACC_W-1:0]   acc_d [ROWS][COLS];
    logic                      out_valid_q, out_valid_d;
    logic [COLS*DATA_W-1:0]    out_data_q, out_data_d;
    logic [RW-1:0]             out_row_q, out_row_d;
    logic                      out_last_q, out_last_d;

    logic                      accept;
    logic                      load_row;
    logic [RW-1:0]             sel_row;
    logic signed [2*DATA_W-1:0] prod;

    // Arithmetic shift, optional ReLU, then clamp into the signed DATA_W range.
    function automatic logic [DATA_W-1:0] sat_out(input logic signed [ACC_W-1:0] v,
                                                  input logic [5:0] sh,
                                                  input logic relu);
        logic signed [ACC_W-1:0] s;
        s = v >>> sh;
        if (relu && s[ACC_W-1]) begin
            s = '0;
        end else if (s > SAT_MAX) begin
            s = SAT_MAX;
        end else if (s < SAT_MIN) begin
            s = SAT_MIN;
        end
        return s[DATA_W-1:0];
    endfunction

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        k_d         = k_q;
        shift_d     = shift_q;
        relu_d      = relu_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_last_d  = out_last_q;
        accept      = 1'b0;
        load_row    = 1'b0;
        sel_row     = out_row_q;
        prod        = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                acc_d[r][c] = acc_q[r][c];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    k_d         = cfg_k;
                    shift_d     = cfg_shift;
                    relu_d      = cfg_relu;
                    beat_cnt_d  = '0;
                    out_row_d   = '0;
                    out_last_d  = 1'b0;
                    out_valid_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (beat_cnt_q == k_q) begin
                        state_d = S_DRAIN;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // First DRAIN cycle fills the output register; afterwards each
                // handshake either advances to the next row or finishes.
                if (!out_valid_q) begin
                    load_row = 1'b1;
                end else if (out_ready) begin
                    if (out_last_q) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b0;
                    end else begin
                        load_row = 1'b1;
                        sel_row  = out_row_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            accept      = 1'b0;
            load_row    = 1'b0;
        end

        if (load_row) begin
            out_valid_d = 1'b1;
            out_row_d   = sel_row;
            out_last_d  = (sel_row == RW'(ROWS - 1));
            for (int c = 0; c < COLS; c++) begin
                out_data_d[c*DATA_W +: DATA_W] = sat_out(acc_q[sel_row][c], shift_q, relu_q);
            end
        end

        // The first beat of a job overwrites the previous job's sums.
        if (accept) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    prod = (2*DATA_W)'($signed(a_data[r*DATA_W +: DATA_W]))
                         * (2*DATA_W)'($signed(b_data[c*DATA_W +: DATA_W]));
                    if (beat_cnt_q == '0) begin
                        acc_d[r][c] = ACC_W'(prod);
                    end else begin
                        acc_d[r][c] = acc_q[r][c] + ACC_W'(prod);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            beat_cnt_q  <= '0;
            k_q         <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_last_q  <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    acc_q[r][c] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            k_q         <= k_d;
            shift_q     <= shift_d;
            relu_q      <= relu_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_last_q  <= out_last_d;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    acc_q[r][c] <= acc_d[r][c];
                end
            end
        end
    end

    assign in_ready  = (state_q == S_LOAD);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE) && !abort;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_pe_tile_array.sv
// Scoreboard bench for pe_tile_array: a behavioural MAC model pushes expected
// rows when a job's last beat is driven; a monitor pops them on each handshake.
module tb_pe_tile_array;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 16;
    localparam int AW   = 40;
    localparam int KW   = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [KW-1:0]        cfg_k = '0;
    logic [5:0]           cfg_shift = '0;
    logic                 cfg_relu = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [ROWS*DW-1:0]   a_data = '0;
    logic [COLS*DW-1:0]   b_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [COLS*DW-1:0]   out_data;
    logic [1:0]           out_row;
    logic                 out_last;
    logic                 busy;
    logic                 done;

    pe_tile_array #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .ACC_W(AW), .K_W(KW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_k(cfg_k), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_data(a_data), .b_data(b_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                  row;
        logic [COLS*DW-1:0]  data;
        bit                  last;
    } exp_t;

    exp_t   sb[$];
    int     total = 0;
    int     bad = 0;
    int     done_cnt = 0;
    longint macc [ROWS][COLS];
    int     beat_idx;
    int     job_k;
    int     job_sh;
    bit     job_relu;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_sat(input longint v, input int sh, input bit relu);
        longint s;
        longint mx;
        logic [63:0] t;
        mx = (longint'(1) <<< (DW - 1)) - 1;
        s  = v >>> sh;
        if (relu && s < 0) s = 0;
        if (s > mx) s = mx;
        if (s < -mx - 1) s = -mx - 1;
        t = s;
        return t[DW-1:0];
    endfunction

    function automatic logic [ROWS*DW-1:0] pack_a(input int base, input int step);
        logic [ROWS*DW-1:0] v;
        logic [31:0] t;
        for (int r = 0; r < ROWS; r++) begin
            t = base + step * r;
            v[r*DW +: DW] = t[DW-1:0];
        end
        return v;
    endfunction

    function automatic logic [COLS*DW-1:0] pack_b(input int base, input int step);
        logic [COLS*DW-1:0] v;
        logic [31:0] t;
        for (int c = 0; c < COLS; c++) begin
            t = base + step * c;
            v[c*DW +: DW] = t[DW-1:0];
        end
        return v;
    endfunction

    // Monitor: a row is taken on the coming rising edge when both handshake
    // signals are high at the falling edge.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_row", 64'(out_row), 64'hFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("row_idx", 64'(out_row), 64'(e.row));
                chk("row_data", 64'(out_data), 64'(e.data));
                chk("row_last", 64'(out_last), 64'(e.last));
            end
        end
    end

    task automatic start_job(input int k, input int sh, input bit relu);
        start = 1'b1;
        cfg_k = KW'(k);
        cfg_shift = 6'(sh);
        cfg_relu = relu;
        @(posedge clk); #1;
        start = 1'b0;
        job_k = k;
        job_sh = sh;
        job_relu = relu;
        beat_idx = 0;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic drive_beat(input logic [ROWS*DW-1:0] av, input logic [COLS*DW-1:0] bv);
        int n;
        exp_t e;
        longint x;
        longint y;
        n = 0;
        a_data = av;
        b_data = bv;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("beat_ready_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                x = $signed(av[r*DW +: DW]);
                y = $signed(bv[c*DW +: DW]);
                macc[r][c] = (beat_idx == 0) ? x * y : macc[r][c] + x * y;
            end
        end
        beat_idx++;
        if (beat_idx == job_k + 1) begin
            for (int r = 0; r < ROWS; r++) begin
                e.row = r;
                e.last = (r == ROWS - 1);
                for (int c = 0; c < COLS; c++) begin
                    e.data[c*DW +: DW] = exp_sat(macc[r][c], job_sh, job_relu);
                end
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_done(input int max_cyc);
        int n;
        n = 0;
        while (!done && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", 64'(done), 64'd1);
        @(posedge clk); #1;
        chk("idle_after_done", 64'(busy), 64'd0);
    endtask

    task automatic wait_out_valid(input int max_cyc);
        int n;
        n = 0;
        while (!out_valid && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        chk("out_valid_seen", 64'(out_valid), 64'd1);
    endtask

    task automatic single_job(input int sh, input bit relu, input int av, input int bv);
        start_job(0, sh, relu);
        drive_beat(pack_a(av, 0), pack_b(bv, 0));
        wait_done(30);
    endtask

    initial begin
        int d0;
        logic [COLS*DW-1:0] held;

        // Reset values while rst is high
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_row", 64'(out_row), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Basic job with latency and single done pulse
        d0 = done_cnt;
        start_job(0, 0, 1'b0);
        drive_beat(pack_a(1, 1), pack_b(1, 1));
        chk("lat_first_cycle", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("lat_second_cycle", 64'(out_valid), 64'd1);
        wait_done(30);
        repeat (3) @(posedge clk); #1;
        chk("done_once", 64'(done_cnt - d0), 64'd1);

        // Accumulate with stalls; cfg changes after start must not matter
        start_job(2, 0, 1'b0);
        cfg_k = 8'd0; cfg_shift = 6'd4; cfg_relu = 1'b1;
        for (int b = 0; b < 3; b++) begin
            drive_beat(pack_a(2, 0), pack_b(3, 0));
            if (b < 2) begin
                repeat (2) @(posedge clk); #1;
                chk("stall_in_ready", 64'(in_ready), 64'd1);
            end
        end
        wait_done(30);
        single_job(0, 1'b0, 1, 1);

        // Saturation, shift, relu
        single_job(0, 1'b0, 32'h7FFF, 32'h7FFF);
        single_job(15, 1'b0, 32'h7FFF, 32'h7FFF);
        single_job(0, 1'b1, -32768, 32'h7FFF);
        single_job(0, 1'b0, -32768, 32'h7FFF);
        single_job(3, 1'b0, -5, 7);

        // Backpressure on row 1
        out_ready = 1'b0;
        start_job(0, 0, 1'b0);
        drive_beat(pack_a(-3, 2), pack_b(5, -4));
        wait_out_valid(10);
        chk("bp_row0", 64'(out_row), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        held = out_data;
        chk("bp_row1", 64'(out_row), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_row", 64'(out_row), 64'd1);
            chk("bp_hold_data", 64'(out_data), 64'(held));
        end
        out_ready = 1'b1;
        wait_done(30);

        // Abort during beat 1 of a 4-beat job
        d0 = done_cnt;
        start_job(3, 0, 1'b0);
        drive_beat(pack_a(1, 0), pack_b(1, 0));
        in_valid = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        in_valid = 1'b0;
        chk("abort_idle", 64'(busy), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd0);
        repeat (4) @(posedge clk); #1;
        chk("abort_no_out", 64'(out_valid), 64'd0);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);

        // start held high through DRAIN and DONE is ignored
        start_job(0, 0, 1'b0);
        drive_beat(pack_a(1, 1), pack_b(2, 0));
        start = 1'b1;
        cfg_k = 8'd5;
        wait_done(30);
        start = 1'b0;
        @(posedge clk); #1;
        chk("start_masked_idle", 64'(busy), 64'd0);

        // Async reset mid-drain
        out_ready = 1'b0;
        start_job(0, 0, 1'b0);
        drive_beat(pack_a(2, 0), pack_b(2, 0));
        wait_out_valid(10);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_data", 64'(out_data), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_out_row", 64'(out_row), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("post_rst_idle", 64'(busy), 64'd0);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        single_job(0, 1'b0, 1, 1);

        repeat (3) @(posedge clk); #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1);
    end

endmodule
